// File: rtl/pkt_proc_sequencer.sv
// Packet hand-off sequencer between the FIFO FSM and the embedded CPU.
// Optional watchdog (timeout limit, command 3'b110, timeout_count) enabled by `SEQ_WATCHDOG_EN.
module pkt_proc_sequencer #(
  parameter int                       TIMEOUT_WIDTH  = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int                       CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 end_of_pkt,
  input  logic                 cpu_mode_bit,
  input  logic                 cpu_done,
  input  logic [2:0]           soft_cmd,
  input  logic [31:0]          soft_data,
  output logic                 cpu_start,
  output logic                 cpu_run,
  output logic                 processing_done,
  output logic [2:0]           seq_state,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] timeout_count,
  output logic                 seq_overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    RUN       = 3'd2,
    DONE      = 3'd3,
    WAIT_EXIT = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 pending_q, pending_d;
  logic [2:0]           soft_cmd_q, soft_cmd_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 seq_overrun_q, seq_overrun_d;
  logic                 cmd_edge, cmd_clear, cmd_force, cmd_load;
  logic                 wd_fire;
  logic                 soft_data_unused;

`ifdef SEQ_WATCHDOG_EN
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [TIMEOUT_WIDTH-1:0] timeout_limit_q, timeout_limit_d;
  logic [CNT_WIDTH-1:0]     timeout_count_q, timeout_count_d;

  assign wd_fire = (wd_q == timeout_limit_q - TIMEOUT_WIDTH'(1));
`else
  assign wd_fire = 1'b0;
`endif

  assign soft_data_unused = ^soft_data;

  // Commands act only on the cycle soft_cmd changes, so a held value fires once.
  assign cmd_edge  = (soft_cmd != soft_cmd_q);
  assign cmd_clear = cmd_edge && (soft_cmd == 3'b100);
  assign cmd_force = cmd_edge && (soft_cmd == 3'b101);
  assign cmd_load  = cmd_edge && (soft_cmd == 3'b110);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    soft_cmd_d    = soft_cmd;
    pkt_count_d   = pkt_count_q;
    seq_overrun_d = seq_overrun_q;
`ifdef SEQ_WATCHDOG_EN
    wd_d            = wd_q;
    timeout_limit_d = timeout_limit_q;
    timeout_count_d = timeout_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (end_of_pkt) pending_d = 1'b1;
        if ((pending_q || end_of_pkt) && cpu_mode_bit) state_d = START;
      end
      START: begin
        pending_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = RUN;
      end
      RUN: begin
`ifdef SEQ_WATCHDOG_EN
        wd_d = wd_q + TIMEOUT_WIDTH'(1);
        if (wd_fire && !cpu_done && (timeout_count_q != '1))
          timeout_count_d = timeout_count_q + CNT_WIDTH'(1);
`endif
        if (cpu_done || wd_fire || cmd_force) state_d = DONE;
      end
      DONE: begin
        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        state_d     = WAIT_EXIT;
      end
      WAIT_EXIT: begin
        if (!cpu_mode_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (end_of_pkt && (state_q != IDLE)) seq_overrun_d = 1'b1;

`ifdef SEQ_WATCHDOG_EN
    if (cmd_load)
      timeout_limit_d = (soft_data[TIMEOUT_WIDTH-1:0] == '0) ?
                        TIMEOUT_WIDTH'(1) : soft_data[TIMEOUT_WIDTH-1:0];
`endif

    // Clear is applied last so it overrides any same-cycle increment or set.
    if (cmd_clear) begin
      pkt_count_d   = '0;
      seq_overrun_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
      timeout_count_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      soft_cmd_q    <= '0;
      pkt_count_q   <= '0;
      seq_overrun_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_q            <= '0;
      timeout_limit_q <= TIMEOUT_CYCLES;
      timeout_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      soft_cmd_q    <= soft_cmd_d;
      pkt_count_q   <= pkt_count_d;
      seq_overrun_q <= seq_overrun_d;
`ifdef SEQ_WATCHDOG_EN
      wd_q            <= wd_d;
      timeout_limit_q <= timeout_limit_d;
      timeout_count_q <= timeout_count_d;
`endif
    end
  end

  assign cpu_start       = (state_q == START);
  assign cpu_run         = (state_q == RUN);
  assign processing_done = (state_q == DONE);
  assign seq_state       = state_q;
  assign pkt_count       = pkt_count_q;
  assign seq_overrun     = seq_overrun_q;
`ifdef SEQ_WATCHDOG_EN
  assign timeout_count = timeout_count_q;
`else
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_pkt_proc_sequencer.sv
// Scoreboard bench for pkt_proc_sequencer: expected cpu_start/processing_done pulses are
// queued with their cycle numbers and a monitor matches them against the DUT.
module tb_pkt_proc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        end_of_pkt;
  logic        cpu_mode_bit;
  logic        cpu_done;
  logic [2:0]  soft_cmd;
  logic [31:0] soft_data;
  logic        cpu_start;
  logic        cpu_run;
  logic        processing_done;
  logic [2:0]  seq_state;
  logic [31:0] pkt_count;
  logic [31:0] timeout_count;
  logic        seq_overrun;

  pkt_proc_sequencer #(
    .TIMEOUT_WIDTH (16),
    .TIMEOUT_CYCLES(16'd50000),
    .CNT_WIDTH     (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .end_of_pkt     (end_of_pkt),
    .cpu_mode_bit   (cpu_mode_bit),
    .cpu_done       (cpu_done),
    .soft_cmd       (soft_cmd),
    .soft_data      (soft_data),
    .cpu_start      (cpu_start),
    .cpu_run        (cpu_run),
    .processing_done(processing_done),
    .seq_state      (seq_state),
    .pkt_count      (pkt_count),
    .timeout_count  (timeout_count),
    .seq_overrun    (seq_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 0 = cpu_start, 1 = processing_done
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  exp_pkt = 0;
  int  exp_to  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // end_of_pkt at T, cpu_mode_bit from T+1; returns in the first RUN cycle (T+3).
  task automatic start_pkt(output int t);
    tick();
    t = cyc;
    end_of_pkt = 1'b1;
    push(0, t + 2);
    tick();
    end_of_pkt   = 1'b0;
    cpu_mode_bit = 1'b1;
    run_until(t + 3);
  endtask

  task automatic load_limit(input int v);
    tick();
    soft_cmd  = 3'b110;
    soft_data = v;
    tick();
    soft_cmd  = 3'b000;
    soft_data = '0;
  endtask

  // Monitor: catches missed, unexpected, mistimed or overlapping pulses.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_pulse: kind %0d expected at cycle %0d, absent at cycle %0d",
               exp_q[0].kind, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (cpu_start === 1'b1 || processing_done === 1'b1) begin
      ev_t e;
      int  kind;
      kind = processing_done ? 1 : 0;
      total++;
      if (cpu_start && processing_done) begin
        bad++;
        $display("FAIL pulse_overlap: start=%b done=%b at cycle %0d expected exclusive",
                 cpu_start, processing_done, cyc);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d expected none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
          bad++;
          $display("FAIL pulse_match: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                   kind, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset        = 1'b0;
    end_of_pkt   = 1'b0;
    cpu_mode_bit = 1'b0;
    cpu_done     = 1'b0;
    soft_cmd     = 3'b000;
    soft_data    = '0;
    repeat (3) tick();
    chk("rst_state", seq_state, 0);
    chk("rst_cpu_start", cpu_start, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_proc_done", processing_done, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_timeout_count", timeout_count, 0);
    chk("rst_overrun", seq_overrun, 0);
    reset = 1'b1;
    tick();

    // Basic hand-off
    start_pkt(t);
    chk("basic_cpu_run", cpu_run, 1);
    run_until(t + 6);
    cpu_done = 1'b1;
    push(1, t + 7);
    exp_pkt++;
    tick();
    cpu_done = 1'b0;
    tick();
    chk("basic_pkt_count", pkt_count, exp_pkt);
    chk("basic_wait_exit", seq_state, 4);
    cpu_mode_bit = 1'b0;
    tick();
    chk("basic_back_idle", seq_state, 0);

`ifdef SEQ_WATCHDOG_EN
    // Watchdog limit 5: RUN for cycles t+3..t+7
    load_limit(5);
    start_pkt(t);
    run_until(t + 7);
    chk("wd_still_run", seq_state, 2);
    push(1, t + 8);
    exp_pkt++;
    exp_to++;
    run_until(t + 10);
    chk("wd_timeout_count", timeout_count, exp_to);
    chk("wd_pkt_count", pkt_count, exp_pkt);
    cpu_mode_bit = 1'b0;
    tick();

    // cpu_done coincident with expiry: no timeout counted
    start_pkt(t);
    run_until(t + 7);
    cpu_done = 1'b1;
    push(1, t + 8);
    exp_pkt++;
    tick();
    cpu_done = 1'b0;
    run_until(t + 10);
    chk("tie_timeout_count", timeout_count, exp_to);
    chk("tie_pkt_count", pkt_count, exp_pkt);
    cpu_mode_bit = 1'b0;
    tick();

    // Limit 0 loads as 1: single RUN cycle
    load_limit(0);
    start_pkt(t);
    push(1, t + 4);
    exp_pkt++;
    exp_to++;
    run_until(t + 6);
    chk("lim0_timeout_count", timeout_count, exp_to);
    cpu_mode_bit = 1'b0;
    tick();
    load_limit(100);
`else
    // Without the watchdog, RUN waits indefinitely for cpu_done
    load_limit(5);
    start_pkt(t);
    run_until(t + 12);
    chk("nowd_still_run", seq_state, 2);
    chk("nowd_timeout_count", timeout_count, 0);
    cpu_done = 1'b1;
    push(1, t + 13);
    exp_pkt++;
    tick();
    cpu_done = 1'b0;
    run_until(t + 15);
    chk("nowd_pkt_count", pkt_count, exp_pkt);
    cpu_mode_bit = 1'b0;
    tick();
`endif

    // Force release during RUN
    start_pkt(t);
    run_until(t + 4);
    soft_cmd = 3'b101;
    push(1, t + 5);
    exp_pkt++;
    run_until(t + 7);
    cpu_mode_bit = 1'b0;
    soft_cmd     = 3'b000;
    tick();
    chk("force_idle", seq_state, 0);
    chk("force_pkt_count", pkt_count, exp_pkt);

    // Force edge in IDLE is ignored; held value does not act later in RUN
    tick();
    soft_cmd = 3'b101;
    tick();
    tick();
    chk("force_idle_ignored", seq_state, 0);
    start_pkt(t);
    run_until(t + 5);
    chk("held_cmd_no_force", seq_state, 2);
    cpu_done = 1'b1;
    push(1, t + 6);
    exp_pkt++;
    tick();
    cpu_done = 1'b0;
    soft_cmd = 3'b000;
    run_until(t + 8);
    chk("held_pkt_count", pkt_count, exp_pkt);
    cpu_mode_bit = 1'b0;
    tick();
    tick();

    // Overrun, then clear in the same cycle as the DONE increment
    start_pkt(t);
    run_until(t + 4);
    end_of_pkt = 1'b1;
    tick();
    end_of_pkt = 1'b0;
    chk("overrun_set", seq_overrun, 1);
    run_until(t + 6);
    cpu_done = 1'b1;
    push(1, t + 7);
    tick();
    cpu_done = 1'b0;
    soft_cmd = 3'b100;
    exp_pkt  = 0;
    exp_to   = 0;
    tick();
    soft_cmd = 3'b000;
    chk("clear_pkt_count", pkt_count, exp_pkt);
    chk("clear_timeout_count", timeout_count, exp_to);
    chk("clear_overrun", seq_overrun, 0);
    cpu_mode_bit = 1'b0;
    tick();
    cpu_mode_bit = 1'b1;
    repeat (3) tick();
    chk("no_pending_from_overrun", seq_state, 0);
    cpu_mode_bit = 1'b0;
    tick();

    // Reset in the middle of RUN
    start_pkt(t);
    run_until(t + 4);
    reset = 1'b0;
    tick();
    chk("midrst_state", seq_state, 0);
    chk("midrst_cpu_run", cpu_run, 0);
    chk("midrst_cpu_start", cpu_start, 0);
    chk("midrst_proc_done", processing_done, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    chk("midrst_overrun", seq_overrun, 0);
    reset        = 1'b1;
    cpu_mode_bit = 1'b0;
    repeat (4) tick();

    chk("events_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_proc_sequencer.md
# pkt_proc_sequencer

Controller that sequences the hand-off of a captured packet between the packet FIFO FSM and the embedded processor. It detects a completed packet, starts the processor, supervises execution with a watchdog, and issues the `processing_done` pulse that returns the FIFO FSM to packet capture. Software can force a release and clear status over the `soft_cmd`/`soft_data` interface.

## Interface
- `TIMEOUT_WIDTH`, 16: width of the watchdog counter and of the timeout limit.
- `TIMEOUT_CYCLES`, 16'd50000: reset value of the timeout limit, in RUN cycles.
- `CNT_WIDTH`, 32: width of `pkt_count` and `timeout_count`.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `end_of_pkt`  in  1  one-cycle pulse from the FIFO FSM: last word of a packet was captured.
- `cpu_mode_bit`  in  1  from the FIFO FSM; high while the packet is held for the CPU.
- `cpu_done`  in  1  processor finished the current packet. Level or pulse; sampled only in RUN.
- `soft_cmd`  in  3  software command.
- `soft_data`  in  32  software command operand.
- `cpu_start`  out  1  one-cycle pulse that starts the processor on the held packet.
- `cpu_run`  out  1  high while the processor may execute.
- `processing_done`  out  1  one-cycle pulse to the FIFO FSM that releases the packet.
- `seq_state`  out  3  current state encoding, for the logic analyzer.
- `pkt_count`  out  CNT_WIDTH  number of packets released. Wraps.
- `timeout_count`  out  CNT_WIDTH  number of watchdog expiries. Saturates at all-ones.
- `seq_overrun`  out  1  sticky flag: `end_of_pkt` arrived outside IDLE.

## Operation
- State encoding: IDLE=0, START=1, RUN=2, DONE=3, WAIT_EXIT=4.
- IDLE:
  - `end_of_pkt` sets the internal flag `pending`.
  - When `pending` or `end_of_pkt` is high and `cpu_mode_bit`=1, move to START.
- START (1 cycle):
  - `cpu_start`=1.
  - Watchdog counter cleared to 0; `pending` cleared.
  - Move to RUN.
- RUN:
  - `cpu_run`=1; the watchdog increments each cycle.
  - Exit to DONE on the first of: `cpu_done`=1; watchdog equal to `timeout_limit`-1; software force release.
  - `timeout_count` increments only when the watchdog fires and `cpu_done` is low in the same cycle. `cpu_done` has priority.
- DONE (1 cycle):
  - `processing_done`=1 and `pkt_count` increments.
  - Move to WAIT_EXIT.
- WAIT_EXIT: remain until `cpu_mode_bit`=0, then move to IDLE.
- Software commands:
  - A command executes once, on the cycle `soft_cmd` differs from its value registered on the previous cycle.
  - 3'b100: clear `pkt_count`, `timeout_count` and `seq_overrun`.
  - 3'b101: force release. Acts only in RUN; ignored elsewhere.
  - 3'b110: load `timeout_limit` from `soft_data[TIMEOUT_WIDTH-1:0]`. A value of 0 is loaded as 1.
  - All other values: no operation.
- Clearing counters in the same cycle as an increment: the clear wins and the counter reads 0.
- `end_of_pkt` in START, RUN, DONE or WAIT_EXIT: set `seq_overrun`; `pending` is not set.

## Timing
- Reset (`reset`=0 at an edge):
  - State goes to IDLE; all outputs return to 0.
  - `pending`=0; `timeout_limit`=TIMEOUT_CYCLES; the registered `soft_cmd` copy is 0.
- Reset during RUN aborts the packet with no `processing_done`. The FIFO FSM is reset by the same system reset.
- Typical sequence:
  - `end_of_pkt` at cycle T; `cpu_mode_bit` rises at T+1.
  - START at T+2 (`cpu_start` high for exactly that cycle); RUN from T+3.
- `cpu_done` sampled at cycle R gives DONE (`processing_done` high) at R+1 and `pkt_count` updated at R+2.
- Watchdog with limit L: with no `cpu_done`, RUN lasts exactly L cycles.
- `cpu_start` and `processing_done` are never high for more than one cycle and never high in the same cycle.
- All outputs are registered or decoded directly from registered state; no combinational path from any input to any output.

## Configuration
- `SEQ_WATCHDOG_EN` defined: the watchdog counter, `timeout_limit`, command 3'b110 and `timeout_count` increments are present as described.
- `SEQ_WATCHDOG_EN` undefined:
  - RUN exits only on `cpu_done` or force release.
  - `timeout_count` is constant 0; command 3'b110 is a no-op.
  - No watchdog registers are synthesized.

## Test plan
- Reset, then `end_of_pkt` at T with `cpu_mode_bit` high from T+1 → `cpu_start` at T+2 only; `cpu_done` at T+6 → `processing_done` at T+7; `pkt_count`=1; `cpu_mode_bit` drops → IDLE.
- Watchdog: load limit 5 via `soft_cmd`=3'b110, `soft_data`=5; no `cpu_done` → RUN lasts 5 cycles, then `processing_done`; `timeout_count`=1.
- `cpu_done` and watchdog expiry in the same cycle → `processing_done` asserted; `timeout_count` unchanged.
- Force release: `soft_cmd` 0→3'b101 during RUN → DONE next cycle; holding 3'b101 in IDLE → no effect.
- `end_of_pkt` during RUN → `seq_overrun`=1 and no second `cpu_start`; `soft_cmd`=3'b100 → counters and `seq_overrun` read 0.
- Drive `reset` low mid-RUN → next cycle state IDLE, all outputs 0, no `processing_done` pulse.
